// File: rtl/lif_pkg.sv
// Shared types and default constants for the LIF sweep scheduler.
// Holds the scheduler FSM state enum and the default datapath parameters.
package lif_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_UPDATE,
        S_WAIT_SPIKE
    } sched_state_t;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_THRESHOLD  = 200;
    localparam int DEF_LEAK_SHIFT = 1;

endpackage

// File: rtl/lif_leak_update.sv
// Combinational leak-integrate-threshold step for one neuron.
// Ports: state/cur in (WIDTH), nxt out (saturated update), fire out.
module lif_leak_update
    import lif_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int THRESHOLD  = DEF_THRESHOLD,
    parameter int LEAK_SHIFT = DEF_LEAK_SHIFT
) (
    input  logic [WIDTH-1:0] state,
    input  logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] nxt,
    output logic             fire
);

    // Threshold held one bit wider so the compare never truncates it.
    localparam logic [WIDTH:0] THR = (WIDTH+1)'(THRESHOLD);

    logic [WIDTH-1:0] leak;
    logic [WIDTH:0]   sum;

    always_comb begin
        leak = state >> LEAK_SHIFT;
        // leak <= state, so the subtraction cannot underflow.
        sum  = {1'b0, state} - {1'b0, leak} + {1'b0, cur};
        nxt  = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
        fire = ({1'b0, nxt} >= THR);
    end

endmodule

// File: rtl/lif_sweep_scheduler.sv
// Time-multiplexed LIF neuron array: one update per cycle per tick sweep,
// spike IDs out over valid/ready. Ports: clk, rst (async high), tick,
// cur_wr_en/addr/data, state_rd_addr/data, busy, spike_valid/ready/id,
// overrun_cnt (only when LIF_SCHED_OVERRUN_EN is defined).
module lif_sweep_scheduler
    import lif_pkg::*;
#(
    parameter int N_NEURONS  = 4,
    parameter int WIDTH      = DEF_WIDTH,
    parameter int THRESHOLD  = DEF_THRESHOLD,
    parameter int LEAK_SHIFT = DEF_LEAK_SHIFT,
    localparam int AW        = $clog2(N_NEURONS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             cur_wr_en,
    input  logic [AW-1:0]    cur_wr_addr,
    input  logic [WIDTH-1:0] cur_wr_data,
    input  logic [AW-1:0]    state_rd_addr,
    output logic [WIDTH-1:0] state_rd_data,
    output logic             busy,
    output logic             spike_valid,
    input  logic             spike_ready,
    output logic [AW-1:0]    spike_id
`ifdef LIF_SCHED_OVERRUN_EN
    ,
    output logic [7:0]       overrun_cnt
`endif
);

    localparam logic [AW-1:0] LAST = AW'(N_NEURONS - 1);

    logic [WIDTH-1:0] cur_mem   [N_NEURONS];
    logic [WIDTH-1:0] state_mem [N_NEURONS];

    sched_state_t     fsm;
    logic [AW-1:0]    idx;
    logic [AW-1:0]    pend_id;

    logic [WIDTH-1:0] upd_nxt;
    logic             upd_fire;
    logic             slot_free;

    assign state_rd_data = state_mem[state_rd_addr];
    assign slot_free     = !spike_valid || spike_ready;

    lif_leak_update #(
        .WIDTH      (WIDTH),
        .THRESHOLD  (THRESHOLD),
        .LEAK_SHIFT (LEAK_SHIFT)
    ) u_upd (
        .state (state_mem[idx]),
        .cur   (cur_mem[idx]),
        .nxt   (upd_nxt),
        .fire  (upd_fire)
    );

    // Host current loader; a write landing on the neuron being updated
    // only becomes visible after this cycle's registered read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_NEURONS; i++)
                cur_mem[i] <= '0;
        end else if (cur_wr_en) begin
            cur_mem[cur_wr_addr] <= cur_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm         <= S_IDLE;
            idx         <= '0;
            pend_id     <= '0;
            busy        <= 1'b0;
            spike_valid <= 1'b0;
            spike_id    <= '0;
            for (int i = 0; i < N_NEURONS; i++)
                state_mem[i] <= '0;
        end else begin
            // Accepted event leaves the slot; a new load below overrides.
            if (spike_valid && spike_ready)
                spike_valid <= 1'b0;

            case (fsm)
                S_IDLE: begin
                    if (tick) begin
                        idx  <= '0;
                        fsm  <= S_UPDATE;
                        busy <= 1'b1;
                    end
                end

                S_UPDATE: begin
                    state_mem[idx] <= upd_fire ? '0 : upd_nxt;
                    if (upd_fire && !slot_free) begin
                        // Hold idx; resume once the slot drains.
                        pend_id <= idx;
                        fsm     <= S_WAIT_SPIKE;
                    end else begin
                        if (upd_fire) begin
                            spike_id    <= idx;
                            spike_valid <= 1'b1;
                        end
                        idx <= idx + 1'b1;
                        if (idx == LAST) begin
                            fsm  <= S_IDLE;
                            busy <= 1'b0;
                        end
                    end
                end

                S_WAIT_SPIKE: begin
                    if (spike_ready) begin
                        spike_id    <= pend_id;
                        spike_valid <= 1'b1;
                        idx         <= idx + 1'b1;
                        if (idx == LAST) begin
                            fsm  <= S_IDLE;
                            busy <= 1'b0;
                        end else begin
                            fsm  <= S_UPDATE;
                        end
                    end
                end

                default: begin
                    fsm  <= S_IDLE;
                    busy <= 1'b0;
                end
            endcase
        end
    end

`ifdef LIF_SCHED_OVERRUN_EN
    // Counts ticks dropped because a sweep was still running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            overrun_cnt <= '0;
        else if (tick && busy && overrun_cnt != 8'hff)
            overrun_cnt <= overrun_cnt + 1'b1;
    end
`endif

endmodule

// File: doc/lif_sweep_scheduler.md
# lif_sweep_scheduler

Time-multiplexes one leaky-integrate-and-fire update datapath across `N_NEURONS` virtual neurons. Each neuron has a stored membrane state and input current. On each `tick` the block sweeps all neurons in index order, one per cycle, and applies leak, integration, threshold and reset. Spike events go out as neuron IDs over a valid/ready port. The block sits between the host-side current loader and the spike consumer (output pins or a downstream neuron layer).

## Interface
Parameters:
- `N_NEURONS`, 4: number of virtual neurons; power of two, ≥2.
- `WIDTH`, 8: width of state and current.
- `THRESHOLD`, 200: spike fires when the updated state is ≥ this value.
- `LEAK_SHIFT`, 1: leak per update is `state >> LEAK_SHIFT`.

Ports:
- `clk` in 1: clock. Single clock domain.
- `rst` in 1: asynchronous, active-high reset.
- `tick` in 1: one-cycle pulse; starts a sweep.
- `cur_wr_en` in 1: write strobe for the current register.
- `cur_wr_addr` in log2(N_NEURONS): neuron index to write.
- `cur_wr_data` in WIDTH: input current value.
- `state_rd_addr` in log2(N_NEURONS): neuron index for the debug read.
- `state_rd_data` out WIDTH: combinational read of `state[state_rd_addr]`.
- `busy` out 1: high while a sweep is in progress.
- `spike_valid` out 1: a spike event is pending.
- `spike_ready` in 1: consumer accepts the pending event.
- `spike_id` out log2(N_NEURONS): index of the spiking neuron.
- `overrun_cnt` out 8: present only with `LIF_SCHED_OVERRUN_EN`.

## Operation
- FSM states: IDLE, UPDATE, WAIT_SPIKE.
- IDLE:
  - `busy`=0.
  - When `tick`=1: set `idx`=0 and go to UPDATE.
- UPDATE, for neuron `idx`:
  - Compute `leak = s >> LEAK_SHIFT`.
  - Compute `sum = s - leak + cur[idx]` at WIDTH+1 bits.
  - Saturate `sum` to 2^WIDTH-1 to get `nxt`.
  - `fire = (nxt >= THRESHOLD)`.
  - Write `state[idx]`: 0 if `fire`, otherwise `nxt`.
- Spike emission in UPDATE:
  - If `fire` and the output slot is free (`!spike_valid || spike_ready`): load `spike_id`=`idx` and set `spike_valid`=1.
  - If `fire` and the slot is still occupied: latch `pend_id`=`idx` and go to WAIT_SPIKE.
- Index advance: when not stalled, `idx`++. After `idx`=N_NEURONS-1, return to IDLE.
- WAIT_SPIKE:
  - When `spike_ready`=1: load `spike_id`=`pend_id` (keeping `spike_valid` at 1).
  - Then advance `idx` exactly as UPDATE does (continue the sweep, or return to IDLE after the last neuron).
- Handshake:
  - A transfer occurs when `spike_valid && spike_ready`.
  - With no new event in that cycle, `spike_valid` clears on the next edge.
  - `spike_id` is stable while `spike_valid && !spike_ready`.
- `tick` while `busy`=1 is ignored.
- Current writes:
  - Accepted in any state.
  - A write to the neuron in its own UPDATE cycle is not used in that cycle; it takes effect at the next sweep.
  - Writes to neurons not yet updated in the current sweep are used in this sweep.
- Reset:
  - All states and currents go to 0.
  - `spike_valid`=0, `spike_id`=0, `busy`=0, `idx`=0, FSM to IDLE.
  - Reset in mid-sweep aborts the sweep; the partial updates are discarded by the reset.

## Timing
- `busy` rises the cycle after `tick` and falls after the last UPDATE or WAIT_SPIKE cycle.
- An unstalled sweep lasts exactly N_NEURONS cycles.
- `spike_valid` rises on the edge that ends the firing neuron's UPDATE cycle (latency 1).
- Each stall adds the cycles spent waiting for `spike_ready`.
- `state_rd_data` reflects writes one cycle after the write edge.
- Back-to-back spikes with `spike_ready` held at 1 give one event per cycle.

## Configuration
- `LIF_SCHED_OVERRUN_EN` defined:
  - `overrun_cnt` port exists, with reset value 0.
  - It increments on each `tick` that arrives while `busy`=1, saturating at 255.
- Without the macro: the port and counter are absent; ignored ticks leave no trace.

## Structure
- Shared package `lif_pkg` holds:
  - the FSM state enum `sched_state_t`;
  - the default `WIDTH`, `THRESHOLD` and `LEAK_SHIFT` constants.
- One combinational sub-module, `lif_leak_update`:
  - inputs: state, current;
  - outputs: next state, fire;
  - contains the saturation and threshold logic;
  - parameterised by `WIDTH`, `THRESHOLD`, `LEAK_SHIFT`.
- Storage (current and state register arrays), the FSM and the spike output register live in the top.

## Test plan
All scenarios use the default parameters.
- Reset: hold `rst`=1 → `busy`=0, `spike_valid`=0, `state_rd_data`=0 for every address, and `overrun_cnt`=0.
- Integration and spike:
  - Set `cur[0]`=150 and tick. Sweep lasts 4 cycles; `state[0]`=150 and there is no spike.
  - Tick again: 150-75+150=225 ≥ 200 → `spike_id`=0 with `spike_valid` one cycle after neuron 0's UPDATE, and `state[0]`=0.
- Saturation: set `cur[1]`=199 and tick twice. The second update sums to 299, saturates to 255 and fires; `state[1]`=0.
- Backpressure:
  - Set all currents to 255, hold `spike_ready`=0 and tick. `spike_id`=0 is held and `busy` stays 1.
  - Then raise `spike_ready` → IDs 0,1,2,3 in order, one per accepted transfer. `busy` falls after neuron 3.
- Overrun (macro defined): pulse `tick` twice during a sweep → both are ignored, `overrun_cnt`=2 and the sweep length is unchanged.
- Reset mid-sweep: assert `rst` in neuron 2's UPDATE cycle → all outputs return to reset values. A subsequent tick starts a fresh sweep at `idx`=0.
